// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_pkg                                                                  |
// | Shared video types: pixel, raster timing record, timing presets, bar       |
// | colours (also used as border colour codes) and pattern/FSM encodings.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package video_pkg;

  localparam int RGBW  = 8;   // bits per colour component
  localparam int CNT_W = 12;  // raster counter / coordinate width

  typedef struct packed {
    logic [RGBW-1:0] r;
    logic [RGBW-1:0] g;
    logic [RGBW-1:0] b;
  } pixel_t;

  typedef struct packed {
    int unsigned H_ACTIVE;
    int unsigned H_FP;
    int unsigned H_SYNC;
    int unsigned H_BP;
    int unsigned V_ACTIVE;
    int unsigned V_FP;
    int unsigned V_SYNC;
    int unsigned V_BP;
  } vid_timing_t;

  localparam vid_timing_t TIMING_VGA_640x480 = '{
    H_ACTIVE: 640, H_FP: 16, H_SYNC: 96, H_BP: 48,
    V_ACTIVE: 480, V_FP: 10, V_SYNC: 2,  V_BP: 33
  };

  // Tiny raster for fast simulation
  localparam vid_timing_t TIMING_SIM_16x4 = '{
    H_ACTIVE: 16, H_FP: 2, H_SYNC: 3, H_BP: 3,
    V_ACTIVE: 4,  V_FP: 1, V_SYNC: 1, V_BP: 2
  };

  localparam pixel_t COL_WHITE   = '{r: '1, g: '1, b: '1};
  localparam pixel_t COL_YELLOW  = '{r: '1, g: '1, b: '0};
  localparam pixel_t COL_CYAN    = '{r: '0, g: '1, b: '1};
  localparam pixel_t COL_GREEN   = '{r: '0, g: '1, b: '0};
  localparam pixel_t COL_MAGENTA = '{r: '1, g: '0, b: '1};
  localparam pixel_t COL_RED     = '{r: '1, g: '0, b: '0};
  localparam pixel_t COL_BLUE    = '{r: '0, g: '0, b: '1};
  localparam pixel_t COL_BLACK   = '{r: '0, g: '0, b: '0};

  typedef enum logic [1:0] {
    PAT_BARS  = 2'b00,
    PAT_RAMP  = 2'b01,
    PAT_CHECK = 2'b10,
    PAT_BLACK = 2'b11
  } pat_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } tg_state_e;

  // Colour of bar idx, left (0) to right (7)
  function automatic pixel_t bar_colour(input logic [2:0] idx);
    pixel_t c;
    c = COL_BLACK;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vid_sideband_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vid_sideband_if                                                            |
// | Per-pixel sideband travelling alongside the pixel bus between stages.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface vid_sideband_if;
  import video_pkg::*;

  logic             de;
  logic             sof;
  logic             eol;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;

  modport source (output de, sof, eol, x, y);
  modport sink   (input  de, sof, eol, x, y);

endinterface
`default_nettype wire

// File: rtl/vid_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vid_timing_gen                                                             |
// | Raster counters, run/stop FSM, registered syncs, de/sof/eol/x/y and        |
// | frame_done. Also exports the live counter state for the pattern stage.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vid_timing_gen
  import video_pkg::*;
#(
  parameter vid_timing_t T        = TIMING_VGA_640x480,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  // live (unregistered) counter view for the pattern stage
  output logic             o_running,
  output logic             o_active,
  output logic             o_line_end,
  output logic             o_pat_latch,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  // registered outputs
  output logic             o_de,
  output logic             o_sof,
  output logic             o_eol,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_done
);

  localparam logic [CNT_W-1:0] c_H_ACT  = CNT_W'(T.H_ACTIVE);
  localparam logic [CNT_W-1:0] c_H_EOL  = CNT_W'(T.H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(T.H_ACTIVE + T.H_FP + T.H_SYNC + T.H_BP - 1);
  localparam logic [CNT_W-1:0] c_HS_BEG = CNT_W'(T.H_ACTIVE + T.H_FP);
  localparam logic [CNT_W-1:0] c_HS_END = CNT_W'(T.H_ACTIVE + T.H_FP + T.H_SYNC);
  localparam logic [CNT_W-1:0] c_V_ACT  = CNT_W'(T.V_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_LAST = CNT_W'(T.V_ACTIVE + T.V_FP + T.V_SYNC + T.V_BP - 1);
  localparam logic [CNT_W-1:0] c_VS_BEG = CNT_W'(T.V_ACTIVE + T.V_FP);
  localparam logic [CNT_W-1:0] c_VS_END = CNT_W'(T.V_ACTIVE + T.V_FP + T.V_SYNC);

  tg_state_e        r_state;
  tg_state_e        w_state_nxt;
  logic             w_run;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_h_end;
  logic             w_wrap;
  logic             w_active;
  logic             w_hs_win;
  logic             w_vs_win;

  logic             r_de;
  logic             r_sof;
  logic             r_eol;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_done;

  assign w_h_end  = (r_h == c_H_LAST);
  assign w_wrap   = w_h_end && (r_v == c_V_LAST);
  assign w_active = w_run && (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_hs_win = w_run && (r_h >= c_HS_BEG) && (r_h < c_HS_END);
  assign w_vs_win = w_run && (r_v >= c_VS_BEG) && (r_v < c_VS_END);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; counters only advance outside IDLE, stop only at frame wrap
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (!i_en) w_state_nxt = ST_STOP_PEND;
      end
      ST_STOP_PEND: begin
        w_run = 1'b1;
        if (i_en)        w_state_nxt = ST_RUN;
        else if (w_wrap) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Raster counters: h wraps every line, v wraps every frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_run) begin
      if (w_h_end) begin
        r_h <= '0;
        r_v <= (r_v == c_V_LAST) ? '0 : r_v + CNT_W'(1);
      end else begin
        r_h <= r_h + CNT_W'(1);
      end
    end
  end

  // Registered outputs describe the counter position of the current cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de         <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_frame_done <= 1'b0;
    end else begin
      r_de         <= w_active;
      r_sof        <= w_active && (r_h == '0) && (r_v == '0);
      r_eol        <= w_active && (r_h == c_H_EOL);
      r_x          <= w_active ? r_h : '0;
      r_y          <= w_active ? r_v : '0;
      r_hsync      <= w_hs_win ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vs_win ? SYNC_POL : ~SYNC_POL;
      r_frame_done <= w_run && w_wrap;
    end
  end

  assign o_running    = w_run;
  assign o_active     = w_active;
  assign o_line_end   = w_h_end;
  assign o_pat_latch  = (r_state == ST_RUN) && (r_h == '0) && (r_v == '0);
  assign o_h_cnt      = r_h;
  assign o_v_cnt      = r_v;
  assign o_de         = r_de;
  assign o_sof        = r_sof;
  assign o_eol        = r_eol;
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: rtl/vid_pattern_src.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vid_pattern_src                                                            |
// | Video source: raster timing plus test-pattern pixel generation (colour     |
// | bars, gray ramp, checker, black). Pixel register shares the timing edge    |
// | so pixel, syncs and sideband stay aligned.                                 |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vid_pattern_src
  import video_pkg::*;
#(
  parameter vid_timing_t T        = TIMING_VGA_640x480,
  parameter int          RAMP_SH  = 2,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            pat_sel,
  output pixel_t                px_out,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_done,
  vid_sideband_if.source        sb_out
);

  // Bars are built from a pixel-in-bar counter, which needs an exact width
  generate
    if ((T.H_ACTIVE % 8) != 0) begin : g_h_active_chk
      $error("vid_pattern_src: H_ACTIVE must be a multiple of 8");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_BAR_LAST = CNT_W'(T.H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] c_CHK_BIT  = CNT_W'(32);

  logic             w_running;
  logic             w_active;
  logic             w_line_end;
  logic             w_pat_latch;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_de;
  logic             w_sof;
  logic             w_eol;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;

  logic [1:0]       r_pat_q;
  logic [1:0]       w_pat;
  logic [2:0]       r_bar;
  logic [CNT_W-1:0] r_pix;
  logic [RGBW-1:0]  w_lvl;
  pixel_t           w_px;
  pixel_t           r_px;

  vid_timing_gen #(
    .T        (T),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .o_running    (w_running),
    .o_active     (w_active),
    .o_line_end   (w_line_end),
    .o_pat_latch  (w_pat_latch),
    .o_h_cnt      (w_h),
    .o_v_cnt      (w_v),
    .o_de         (w_de),
    .o_sof        (w_sof),
    .o_eol        (w_eol),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_frame_done (frame_done)
  );

  // The frame origin uses the new selection directly so frame 0 pixel is not stale
  assign w_pat = w_pat_latch ? pat_sel : r_pat_q;

  // Pattern select only changes at frame start (tracks freely while idle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_pat_q <= 2'b00;
    else if (!w_running || w_pat_latch) r_pat_q <= pat_sel;
  end

  // Bar index and pixel-in-bar counters follow h_cnt, cleared at line start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar <= '0;
      r_pix <= '0;
    end else if (!w_running || w_line_end) begin
      r_bar <= '0;
      r_pix <= '0;
    end else if (r_pix == c_BAR_LAST) begin
      r_pix <= '0;
      r_bar <= r_bar + 3'd1;
    end else begin
      r_pix <= r_pix + CNT_W'(1);
    end
  end

  // Pixel for the current counter position; black outside active video
  always_comb begin
    w_px  = COL_BLACK;
    w_lvl = RGBW'(w_h >> RAMP_SH);
    if (w_active) begin
      case (pat_sel_e'(w_pat))
        PAT_BARS:  w_px = bar_colour(r_bar);
        PAT_RAMP:  w_px = '{r: w_lvl, g: w_lvl, b: w_lvl};
        PAT_CHECK: w_px = (((w_h ^ w_v) & c_CHK_BIT) != '0) ? COL_WHITE : COL_BLACK;
        default:   w_px = COL_BLACK;
      endcase
    end
  end

  // Pixel register, same edge as the timing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_px <= COL_BLACK;
    else        r_px <= w_px;
  end

  assign px_out     = r_px;
  assign sb_out.de  = w_de;
  assign sb_out.sof = w_sof;
  assign sb_out.eol = w_eol;
  assign sb_out.x   = w_x;
  assign sb_out.y   = w_y;

endmodule
`default_nettype wire

// File: tb/tb_vid_pattern_src.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vid_pattern_src                                                         |
// | Directed bench for vid_pattern_src on the 16x4 simulation raster           |
// | (H_TOTAL=24, V_TOTAL=8, BAR_W=2, active-low syncs).                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_vid_pattern_src;
  import video_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] pat_sel;
  pixel_t     px_out;
  logic       hsync;
  logic       vsync;
  logic       frame_done;

  int n_total;
  int n_bad;

  vid_sideband_if sb ();

  vid_pattern_src #(
    .T        (TIMING_SIM_16x4),
    .RAMP_SH  (2),
    .SYNC_POL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pat_sel    (pat_sel),
    .px_out     (px_out),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_done (frame_done),
    .sb_out     (sb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Step one clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the given active pixel is on the outputs (bounded)
  task automatic wait_pos(input int xx, input int yy, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sb.de && sb.x == CNT_W'(xx) && sb.y == CNT_W'(yy)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, found}, 32'd1);
  endtask

  // Advance until sof is on the outputs (bounded)
  task automatic wait_sof(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sb.sof) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, found}, 32'd1);
  endtask

  logic [23:0] bars_exp [16] = '{
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
    24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
    24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
    24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000
  };

  initial begin
    int idle_bad, de_cnt, eol_cnt, eol_x_bad, hs_bad, vs_bad, fd_bad, px_nz;
    int fd_cnt, sof_cnt;
    int hpos, vpos;
    logic [7:0] lvl;

    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    en      = 1'b0;
    pat_sel = 2'b11;

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_de",    {31'd0, sb.de},  32'd0);
    check_eq("rst_px",    {8'd0, px_out},  32'd0);
    check_eq("rst_syncs", {30'd0, hsync, vsync}, 32'd3);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // ---- idle with en low ----
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sb.de || sb.sof || sb.eol || frame_done || px_out != '0 || !hsync || !vsync)
        idle_bad++;
    end
    check_eq("idle_quiet", idle_bad, 0);

    // ---- start, black pattern, full-frame timing ----
    en = 1'b1;
    tick();
    check_eq("start_sof_early", {31'd0, sb.sof}, 32'd0);
    tick();
    check_eq("start_sof", {31'd0, sb.sof}, 32'd1);
    check_eq("start_xy",  {sb.x, 4'd0, sb.y}, 32'd0);

    de_cnt = 0; eol_cnt = 0; eol_x_bad = 0; hs_bad = 0; vs_bad = 0; fd_bad = 0; px_nz = 0;
    for (int k = 0; k < 192; k++) begin
      hpos = k % 24;
      vpos = k / 24;
      if (sb.de) de_cnt++;
      if (sb.eol) begin
        eol_cnt++;
        if (sb.x != CNT_W'(15)) eol_x_bad++;
      end
      if (hsync != ((hpos >= 18 && hpos <= 20) ? 1'b0 : 1'b1)) hs_bad++;
      if (vsync != ((vpos == 5) ? 1'b0 : 1'b1)) vs_bad++;
      if (frame_done != (k == 191)) fd_bad++;
      if (px_out != '0) px_nz++;
      if (k == 100) pat_sel = 2'b00;  // mid-frame change: takes effect next frame
      tick();
    end
    check_eq("frame_de_cnt",  de_cnt, 64);
    check_eq("frame_eol_cnt", eol_cnt, 4);
    check_eq("frame_eol_x",   eol_x_bad, 0);
    check_eq("frame_hsync",   hs_bad, 0);
    check_eq("frame_vsync",   vs_bad, 0);
    check_eq("frame_done_pos", fd_bad, 0);
    check_eq("black_px",      px_nz, 0);
    check_eq("sof_period",    {31'd0, sb.sof}, 32'd1);

    // ---- colour bars, first line ----
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("bars_x%0d_pos", i), {20'd0, sb.x}, i);
      check_eq($sformatf("bars_x%0d_px", i),  {8'd0, px_out}, {8'd0, bars_exp[i]});
      tick();
    end

    // ---- switch to checker mid-frame; current frame keeps bars ----
    wait_pos(0, 2, "wait_y2");
    pat_sel = 2'b10;
    wait_pos(2, 3, "wait_y3");
    check_eq("bars_hold", {8'd0, px_out}, 32'hFFFF00);
    tick();
    wait_sof("wait_chk_sof");
    de_cnt = 0; px_nz = 0;
    for (int k = 0; k < 192; k++) begin
      if (sb.de) de_cnt++;
      if (px_out != '0) px_nz++;
      if (k == 50) pat_sel = 2'b01;
      tick();
    end
    check_eq("chk_de_cnt", de_cnt, 64);
    check_eq("chk_px_zero", px_nz, 0);

    // ---- gray ramp, first line ----
    check_eq("ramp_sof", {31'd0, sb.sof}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      lvl = 8'(i >> 2);
      check_eq($sformatf("ramp_x%0d", i), {8'd0, px_out}, {8'd0, lvl, lvl, lvl});
      tick();
    end

    // ---- stop request at y=1: frame completes, then idle ----
    wait_pos(0, 1, "wait_stop_pos");
    en = 1'b0;
    fd_cnt = 0; sof_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (frame_done) fd_cnt++;
      if (sb.sof) sof_cnt++;
    end
    check_eq("stop_fd_cnt",  fd_cnt, 1);
    check_eq("stop_sof_cnt", sof_cnt, 0);
    check_eq("stop_idle",    {29'd0, sb.de, hsync, vsync}, 32'd3);
    en = 1'b1;
    tick();
    check_eq("restart_sof_early", {31'd0, sb.sof}, 32'd0);
    tick();
    check_eq("restart_sof", {31'd0, sb.sof}, 32'd1);
    check_eq("restart_xy",  {sb.x, 4'd0, sb.y}, 32'd0);

    // ---- asynchronous reset mid-frame ----
    wait_pos(7, 2, "wait_rst_pos");
    rst_n = 1'b0;
    #1;
    check_eq("arst_sb",   {27'd0, sb.de, sb.sof, sb.eol, frame_done, 1'b0}, 32'd0);
    check_eq("arst_xy",   {sb.x, 4'd0, sb.y}, 32'd0);
    check_eq("arst_px",   {8'd0, px_out}, 32'd0);
    check_eq("arst_sync", {30'd0, hsync, vsync}, 32'd3);
    #1 rst_n = 1'b1;
    tick();
    check_eq("post_rst_sof_early", {31'd0, sb.sof}, 32'd0);
    tick();
    check_eq("post_rst_sof", {31'd0, sb.sof}, 32'd1);
    check_eq("post_rst_xy",  {sb.x, 4'd0, sb.y}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
